wshb_arbiter: RTL and testbench

// - Two-master Wishbone (classic, 32-bit data) arbiter in front of the single SDRAM slave port.
// - M0 is the VGA frame reader. It holds cyc permanently high and does read-only streaming.
// - M1 is a frame writer, e.g. a pattern generator or camera.
// - Fair alternation plus a hold-time limit, so M0's permanent cyc cannot starve M1.
// - Registered grant; combinational request/response mux driven by that grant.

---
 rtl/wshb_arbiter.sv | 98 +++++++++
 tb/tb_wshb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: two-master classic Wishbone arbiter with fair alternation and a hold-time limit for one SDRAM slave
module wshb_arbiter #(
  parameter int ADR_W    = 32,
  parameter int MAX_HOLD = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_cyc,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [31:0]      m0_dat_ms,
  input  logic [3:0]       m0_sel,
  input  logic [2:0]       m0_cti,
  input  logic [1:0]       m0_bte,
  output logic             m0_ack,
  output logic [31:0]      m0_dat_sm,
  output logic             m0_gnt,
  input  logic             m1_cyc,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [31:0]      m1_dat_ms,
  input  logic [3:0]       m1_sel,
  input  logic [2:0]       m1_cti,
  input  logic [1:0]       m1_bte,
  output logic             m1_ack,
  output logic [31:0]      m1_dat_sm,
  output logic             m1_gnt,
  output logic             s_cyc,
  output logic             s_stb,
  output logic             s_we,
  output logic [ADR_W-1:0] s_adr,
  output logic [31:0]      s_dat_ms,
  output logic [3:0]       s_sel,
  output logic [2:0]       s_cti,
  output logic [1:0]       s_bte,
  input  logic             s_ack,
  input  logic [31:0]      s_dat_sm,
  output logic [15:0]      preempt_cnt
);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, state_nx, oth;
  logic last, last_nx, preempt, own1, own_cyc, own_stb, oth_cyc;
  logic [HW-1:0] hold_cnt;
  assign own1    = state == OWN1;
  assign oth     = own1 ? OWN0 : OWN1;
  assign own_cyc = own1 ? m1_cyc : m0_cyc;
  assign own_stb = own1 ? m1_stb : m0_stb;
  assign oth_cyc = own1 ? m0_cyc : m1_cyc;
  // last names the most recent owner, so a tie from IDLE goes to the other master
  always_comb begin
    state_nx = state;
    last_nx  = last;
    preempt  = 1'b0;
    if (state == IDLE)
      state_nx = (m0_cyc && (!m1_cyc || last)) ? OWN0 : m1_cyc ? OWN1 : IDLE;
    else if (!own_cyc) begin
      state_nx = oth_cyc ? oth : IDLE;
      last_nx  = own1;
    end else if (hold_cnt == HOLD_MAX && oth_cyc && (!own_stb || s_ack)) begin
      state_nx = oth;
      last_nx  = own1;
      preempt  = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      hold_cnt    <= '0;
      preempt_cnt <= '0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      hold_cnt <= (state_nx != state) ? '0 :
                  (state != IDLE && oth_cyc && hold_cnt != HOLD_MAX) ? hold_cnt + HW'(1) : hold_cnt;
      if (preempt && ~&preempt_cnt) preempt_cnt <= preempt_cnt + 16'd1;
    end
  end
  assign m0_gnt    = state == OWN0;
  assign m1_gnt    = own1;
  assign s_cyc     = (m0_gnt & m0_cyc) | (m1_gnt & m1_cyc);
  assign s_stb     = (m0_gnt & m0_stb) | (m1_gnt & m1_stb);
  assign s_we      = (m0_gnt & m0_we) | (m1_gnt & m1_we);
  assign s_adr     = m0_gnt ? m0_adr : m1_gnt ? m1_adr : '0;
  assign s_dat_ms  = m0_gnt ? m0_dat_ms : m1_gnt ? m1_dat_ms : '0;
  assign s_sel     = m0_gnt ? m0_sel : m1_gnt ? m1_sel : '0;
  assign s_cti     = m0_gnt ? m0_cti : m1_gnt ? m1_cti : '0;
  assign s_bte     = m0_gnt ? m0_bte : m1_gnt ? m1_bte : '0;
  // acks without a live strobe are not forwarded
  assign m0_ack    = s_ack & m0_gnt & m0_stb;
  assign m1_ack    = s_ack & m1_gnt & m1_stb;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;
endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter: directed scenarios plus randomized traffic against an owner/last/hold reference model
module tb_wshb_arbiter;
  localparam int MH = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m0_adr = 0, m0_dat_ms = 0, m1_adr = 0, m1_dat_ms = 0;
  logic [3:0] m0_sel = 0, m1_sel = 0;
  logic [2:0] m0_cti = 0, m1_cti = 0;
  logic [1:0] m0_bte = 0, m1_bte = 0;
  logic m0_ack, m1_ack, m0_gnt, m1_gnt;
  logic [31:0] m0_dat_sm, m1_dat_sm;
  logic s_cyc, s_stb, s_we, s_ack = 0;
  logic [31:0] s_adr, s_dat_ms, s_dat_sm = 0;
  logic [3:0] s_sel;
  logic [2:0] s_cti;
  logic [1:0] s_bte;
  logic [15:0] preempt_cnt;
  int checks = 0, failures = 0;
  int m_owner = -1, m_last = 1, m_hold = 0, m_pre = 0;

  always #5 clk = ~clk;

  wshb_arbiter #(.ADR_W(32), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_ms(m0_dat_ms),
    .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte), .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm), .m0_gnt(m0_gnt),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_ms(m1_dat_ms),
    .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte), .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm), .m1_gnt(m1_gnt),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms), .s_sel(s_sel),
    .s_cti(s_cti), .s_bte(s_bte), .s_ack(s_ack), .s_dat_sm(s_dat_sm), .preempt_cnt(preempt_cnt)
  );

  // Advance one clock; the reference model decides the next owner from the arbitration rules
  task automatic tick();
    bit cy[2], sb[2];
    int nw, nl, nh, np;
    cy[0] = m0_cyc; cy[1] = m1_cyc; sb[0] = m0_stb; sb[1] = m1_stb;
    nl = m_last; np = m_pre;
    if (m_owner < 0) nw = (cy[0] && cy[1]) ? 1 - m_last : cy[0] ? 0 : cy[1] ? 1 : -1;
    else if (!cy[m_owner]) begin nw = cy[1 - m_owner] ? 1 - m_owner : -1; nl = m_owner; end
    else if (m_hold >= MH - 1 && cy[1 - m_owner] && (!sb[m_owner] || s_ack)) begin
      nw = 1 - m_owner; nl = m_owner; np = (m_pre < 65535) ? m_pre + 1 : m_pre;
    end else nw = m_owner;
    if (nw != m_owner) nh = 0;
    else if (m_owner >= 0 && cy[1 - m_owner]) nh = (m_hold + 1 > MH - 1) ? MH - 1 : m_hold + 1;
    else nh = m_hold;
    if (rst) begin nw = -1; nl = 1; nh = 0; np = 0; end
    @(posedge clk); #1;
    m_owner = nw; m_last = nl; m_hold = nh; m_pre = np;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0; s_ack = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1; tick(); tick(); rst = 0; #1;
    checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt0 got=%b exp=0", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt1 got=%b exp=0", m1_gnt); end
    checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL reset_s_cyc got=%b exp=0", s_cyc); end
    checks++; if (preempt_cnt !== 16'd0) begin failures++; $display("FAIL reset_preempt got=%0d exp=0", preempt_cnt); end
  endtask

  task automatic test_single();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100; m1_stb = 1; #1;
    checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL single_latency got=%b exp=0", m0_gnt); end
    tick();
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL single_gnt got=%b exp=1", m0_gnt); end
    checks++; if (s_cyc !== 1'b1) begin failures++; $display("FAIL single_s_cyc got=%b exp=1", s_cyc); end
    checks++; if (s_adr !== 32'h100) begin failures++; $display("FAIL single_s_adr got=%h exp=100", s_adr); end
    s_ack = 1; #1;
    checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL single_ack0 got=%b exp=1", m0_ack); end
    checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL single_ack1 got=%b exp=0", m1_ack); end
    s_ack = 0; #1;
    checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL single_ack0_low got=%b exp=0", m0_ack); end
    idle_inputs(); tick();
    checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL single_release got=%b exp=0", m0_gnt); end
  endtask

  task automatic test_tie();
    do_reset();
    m0_cyc = 1; m1_cyc = 1; tick();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin failures++; $display("FAIL tie_first got=%b exp=10", {m0_gnt, m1_gnt}); end
    m0_cyc = 0; tick();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin failures++; $display("FAIL tie_handover got=%b exp=01", {m0_gnt, m1_gnt}); end
    m1_cyc = 0; tick();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin failures++; $display("FAIL tie_idle got=%b exp=00", {m0_gnt, m1_gnt}); end
    m0_cyc = 1; m1_cyc = 1; tick();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin failures++; $display("FAIL tie_again got=%b exp=10", {m0_gnt, m1_gnt}); end
    idle_inputs(); tick();
  endtask

  task automatic test_preempt();
    do_reset();
    m0_cyc = 1; m0_stb = 1; s_ack = 1; tick();
    m1_cyc = 1; m1_stb = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL pre_hold%0d got=%b exp=1", i, m0_gnt); end
    end
    tick();
    checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL pre_switch got=%b exp=1", m1_gnt); end
    checks++; if (preempt_cnt !== 16'd1) begin failures++; $display("FAIL pre_cnt1 got=%0d exp=1", preempt_cnt); end
    checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL pre_ack0 got=%b exp=0", m0_ack); end
    checks++; if (m1_ack !== 1'b1) begin failures++; $display("FAIL pre_ack1 got=%b exp=1", m1_ack); end
    repeat (3) tick();
    checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL pre_m1_hold got=%b exp=1", m1_gnt); end
    tick();
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL pre_back got=%b exp=1", m0_gnt); end
    checks++; if (preempt_cnt !== 16'd2) begin failures++; $display("FAIL pre_cnt2 got=%0d exp=2", preempt_cnt); end
    idle_inputs(); tick();
  endtask

  task automatic test_pending();
    do_reset();
    m0_cyc = 1; m0_stb = 1; s_ack = 0; tick();
    m1_cyc = 1; m1_stb = 1;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (m0_gnt !== 1'b1 || m0_ack !== 1'b0) begin failures++; $display("FAIL pend_wait%0d gnt=%b ack=%b exp gnt=1 ack=0", i, m0_gnt, m0_ack); end
    end
    s_ack = 1; #1;
    checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL pend_ack0 got=%b exp=1", m0_ack); end
    checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL pend_ack1 got=%b exp=0", m1_ack); end
    tick();
    checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL pend_switch got=%b exp=1", m1_gnt); end
    checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL pend_nodup got=%b exp=0", m0_ack); end
    checks++; if (preempt_cnt !== 16'd1) begin failures++; $display("FAIL pend_cnt got=%0d exp=1", preempt_cnt); end
    idle_inputs(); tick();
  endtask

  task automatic test_write_burst();
    logic [31:0] base, dat;
    do_reset();
    base = 32'h0004_0000;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF; m1_cti = 3'b010; m1_bte = 2'b00; tick();
    checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b exp=1", m1_gnt); end
    for (int i = 0; i < 8; i++) begin
      dat = $urandom; m1_adr = base + 32'(4 * i); m1_dat_ms = dat; m1_cti = (i == 7) ? 3'b111 : 3'b010; s_ack = 1; #1;
      checks++; if (s_we !== 1'b1) begin failures++; $display("FAIL wr_we%0d got=%b exp=1", i, s_we); end
      checks++; if (s_adr !== base + 32'(4 * i)) begin failures++; $display("FAIL wr_adr%0d got=%h exp=%h", i, s_adr, base + 32'(4 * i)); end
      checks++; if (s_dat_ms !== dat) begin failures++; $display("FAIL wr_dat%0d got=%h exp=%h", i, s_dat_ms, dat); end
      checks++; if (m1_ack !== 1'b1) begin failures++; $display("FAIL wr_ack%0d got=%b exp=1", i, m1_ack); end
      tick();
    end
    checks++; if (preempt_cnt !== 16'd0) begin failures++; $display("FAIL wr_preempt got=%0d exp=0", preempt_cnt); end
    checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL wr_keep got=%b exp=1", m1_gnt); end
    idle_inputs(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_cyc = 1; m0_stb = 1; s_ack = 1; tick();
    m1_cyc = 1; m1_stb = 1;
    repeat (4) tick();
    checks++; if (m1_gnt !== 1'b1 || preempt_cnt !== 16'd1) begin failures++; $display("FAIL rmid_setup gnt1=%b cnt=%0d exp gnt1=1 cnt=1", m1_gnt, preempt_cnt); end
    m0_cyc = 0; m0_stb = 0; s_ack = 0; rst = 1; tick();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin failures++; $display("FAIL rmid_gnt got=%b exp=00", {m0_gnt, m1_gnt}); end
    checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL rmid_s_cyc got=%b exp=0", s_cyc); end
    checks++; if (preempt_cnt !== 16'd0) begin failures++; $display("FAIL rmid_cnt got=%0d exp=0", preempt_cnt); end
    rst = 0; idle_inputs(); tick();
  endtask

  task automatic test_random();
    logic [31:0] exp_adr;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 9) == 0) m1_cyc = ~m1_cyc;
      m0_stb = m0_cyc & 1'($urandom_range(0, 1));
      m1_stb = m1_cyc & 1'($urandom_range(0, 1));
      s_ack = $urandom_range(0, 2) != 0;
      m0_adr = $urandom; m1_adr = $urandom; s_dat_sm = $urandom;
      rst = $urandom_range(0, 149) == 0;
      #1;
      exp_adr = (m_owner == 0) ? m0_adr : (m_owner == 1) ? m1_adr : 32'd0;
      checks++; if (m0_gnt !== (m_owner == 0)) begin failures++; $display("FAIL rnd_gnt0 c=%0d got=%b exp=%b", c, m0_gnt, m_owner == 0); end
      checks++; if (m1_gnt !== (m_owner == 1)) begin failures++; $display("FAIL rnd_gnt1 c=%0d got=%b exp=%b", c, m1_gnt, m_owner == 1); end
      checks++; if (m0_ack !== (m_owner == 0 && m0_stb && s_ack)) begin failures++; $display("FAIL rnd_ack0 c=%0d got=%b", c, m0_ack); end
      checks++; if (m1_ack !== (m_owner == 1 && m1_stb && s_ack)) begin failures++; $display("FAIL rnd_ack1 c=%0d got=%b", c, m1_ack); end
      checks++; if (s_cyc !== ((m_owner == 0 && m0_cyc) || (m_owner == 1 && m1_cyc))) begin failures++; $display("FAIL rnd_s_cyc c=%0d got=%b", c, s_cyc); end
      checks++; if (s_adr !== exp_adr) begin failures++; $display("FAIL rnd_s_adr c=%0d got=%h exp=%h", c, s_adr, exp_adr); end
      checks++; if (preempt_cnt !== 16'(m_pre)) begin failures++; $display("FAIL rnd_preempt c=%0d got=%0d exp=%0d", c, preempt_cnt, m_pre); end
      checks++; if (m0_dat_sm !== s_dat_sm || m1_dat_sm !== s_dat_sm) begin failures++; $display("FAIL rnd_dat_sm c=%0d got=%h/%h exp=%h", c, m0_dat_sm, m1_dat_sm, s_dat_sm); end
      tick();
    end
    rst = 0; idle_inputs(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_preempt();
    test_pending();
    test_write_burst();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
